// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state constants for the single-cycle ALU decode and the multi-cycle ALU.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;
  localparam logic [ALU_OP_W-1:0] ALU_MUL = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_DIV = 4'b1010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // MUL and DIV take the iterative path; everything else completes in one cycle
  function automatic logic is_iterative(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the core control and the multi-cycle ALU.
interface alu_multicycle_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [ALU_OP_W-1:0] aluOP;
  logic [WIDTH-1:0]    operand1;
  logic [WIDTH-1:0]    operand2;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    result;
  logic [WIDTH-1:0]    result_hi;
  logic                zeroFlag;
  logic                ovfFlag;
  logic                busy;

  modport master (
    output in_valid, aluOP, operand1, operand2, out_ready,
    input  in_ready, out_valid, result, result_hi, zeroFlag, ovfFlag, busy
  );

  modport slave (
    input  in_valid, aluOP, operand1, operand2, out_ready,
    output in_ready, out_valid, result, result_hi, zeroFlag, ovfFlag, busy
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Shared one-bit-per-cycle engine: shift-add unsigned multiply and restoring unsigned divide.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt;
  logic             div_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] bq;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH-1:0] hi_n;
  logic             active;
  logic             divzero;

  assign active  = (cnt != '0);
  assign divzero = div_q && (bq == '0);
  assign done    = active && ((cnt == CNT_W'(1)) || divzero);
  assign lo      = lo_n;
  assign hi      = hi_n;

  // lo_n/hi_n are the register values after this cycle's step, so the top can latch them on done
  always_comb begin
    sum     = {1'b0, acc} + (q[0] ? {1'b0, bq} : '0);
    shifted = {acc, q[WIDTH-1]};
    diff    = shifted - {1'b0, bq};
    if (!div_q) begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], q[WIDTH-1:1]};
    end else if (divzero) begin
      hi_n = q;
      lo_n = '1;
    end else if (!diff[WIDTH]) begin
      hi_n = diff[WIDTH-1:0];
      lo_n = {q[WIDTH-2:0], 1'b1};
    end else begin
      hi_n = shifted[WIDTH-1:0];
      lo_n = {q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= 1'b0;
      acc   <= '0;
      q     <= '0;
      bq    <= '0;
    end else if (start) begin
      cnt   <= CNT_W'(WIDTH);
      div_q <= is_div;
      acc   <= '0;
      q     <= a;
      bq    <= b;
    end else if (active) begin
      cnt <= done ? '0 : cnt - CNT_W'(1);
      acc <= hi_n;
      q   <= lo_n;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MUL/DIV behind a valid/ready handshake.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_multicycle_if.slave  bus
);
  logic [1:0]       state;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] hi_q;
  logic             zero_q;
  logic             ovf_q;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
  logic             sc_known;
  logic             accept;
  logic             start;
  logic             it_done;
  logic [WIDTH-1:0] it_lo;
  logic [WIDTH-1:0] it_hi;

  assign a      = bus.operand1;
  assign b      = bus.operand2;
  assign accept = (state == ST_IDLE) && bus.in_valid;
  assign start  = accept && is_iterative(bus.aluOP);

  // Overflow: operand signs agree (B inverted for SUB) but the wrapped result sign differs
  always_comb begin
    sc_res   = '0;
    sc_ovf   = 1'b0;
    sc_known = 1'b1;
    case (bus.aluOP)
      ALU_AND: sc_res = a & b;
      ALU_OR:  sc_res = a | b;
      ALU_XOR: sc_res = a ^ b;
      ALU_NOR: sc_res = ~(a | b);
      ALU_ADD: begin
        sc_res = a + b;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_res = a - b;
        sc_ovf = (a[WIDTH-1] == ~b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: sc_known = 1'b0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_div (bus.aluOP == ALU_DIV),
    .a      (a),
    .b      (b),
    .done   (it_done),
    .lo     (it_lo),
    .hi     (it_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      res_q  <= '0;
      hi_q   <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bus.aluOP == ALU_MUL) begin
              state <= ST_MUL;
            end else if (bus.aluOP == ALU_DIV) begin
              state <= ST_DIV;
            end else begin
              state  <= ST_DONE;
              res_q  <= sc_res;
              hi_q   <= '0;
              zero_q <= sc_known && (sc_res == '0);
              ovf_q  <= sc_ovf;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (it_done) begin
            state  <= ST_DONE;
            res_q  <= it_lo;
            hi_q   <= it_hi;
            zero_q <= (it_lo == '0);
            ovf_q  <= 1'b0;
          end
        end
        default: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE) && !rst;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state == ST_MUL) || (state == ST_DIV);
  assign bus.result    = res_q;
  assign bus.result_hi = hi_q;
  assign bus.zeroFlag  = zero_q;
  assign bus.ovfFlag   = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(32)) bus32 ();
  alu_multicycle_if #(.WIDTH(8))  bus8 ();

  alu_multicycle #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  alu_multicycle #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  // Reference: plain arithmetic on the operands, plus the expected accept-to-valid latency
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi,
                                output logic z, output logic o, output int lat);
    longint s;
    logic [63:0] p;
    logic known;
    lo = 0; hi = 0; o = 0; lat = 1; known = 1;
    case (op)
      4'b0000: lo = a & b;
      4'b0001: lo = a | b;
      4'b0011: lo = a ^ b;
      4'b1100: lo = ~(a | b);
      4'b0010: begin
        lo = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        lo = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: lo = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      4'b1000: begin
        p = 64'(a) * 64'(b);
        lo = p[31:0];
        hi = p[63:32];
        lat = 33;
      end
      4'b1010: begin
        if (b == 0) begin
          lo = 32'hFFFF_FFFF; hi = a; lat = 2;
        end else begin
          lo = a / b; hi = a % b; lat = 33;
        end
      end
      default: known = 0;
    endcase
    z = known && (lo == 0);
  endfunction

  task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cyc);
    @(negedge clk);
    bus32.aluOP = op; bus32.operand1 = a; bus32.operand2 = b; bus32.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus32.in_valid = 1'b0;
    bus32.operand1 = $urandom;
    bus32.operand2 = $urandom;
    lat = 1; busy_cyc = 0;
    @(negedge clk);
    while (!bus32.out_valid && lat < 200) begin
      if (bus32.busy) busy_cyc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic drain32();
    @(negedge clk);
    bus32.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus32.out_ready = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_cyc);
    @(negedge clk);
    bus8.aluOP = op; bus8.operand1 = a; bus8.operand2 = b; bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    bus8.operand1 = 8'($urandom);
    lat = 1; busy_cyc = 0;
    @(negedge clk);
    while (!bus8.out_valid && lat < 200) begin
      if (bus8.busy) busy_cyc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // One op through the 32-bit DUT, every output compared against the model
  task automatic run_check(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] elo, ehi;
    logic ez, eo;
    int elat, lat, bc;
    model(op, a, b, elo, ehi, ez, eo, elat);
    issue32(op, a, b, lat, bc);
    n_cmp += 5;
    if (lat !== elat) begin n_err++; $display("[TB] FAIL %s latency op=%b: got %0d want %0d", tag, op, lat, elat); end
    if (bus32.result !== elo) begin n_err++; $display("[TB] FAIL %s result op=%b a=%h b=%h: got %h want %h", tag, op, a, b, bus32.result, elo); end
    if (bus32.result_hi !== ehi) begin n_err++; $display("[TB] FAIL %s result_hi op=%b a=%h b=%h: got %h want %h", tag, op, a, b, bus32.result_hi, ehi); end
    if (bus32.zeroFlag !== ez) begin n_err++; $display("[TB] FAIL %s zeroFlag op=%b: got %b want %b", tag, op, bus32.zeroFlag, ez); end
    if (bus32.ovfFlag !== eo) begin n_err++; $display("[TB] FAIL %s ovfFlag op=%b: got %b want %b", tag, op, bus32.ovfFlag, eo); end
    drain32();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus32.in_valid = 0; bus32.out_ready = 0; bus32.aluOP = 0; bus32.operand1 = 0; bus32.operand2 = 0;
    bus8.in_valid = 0; bus8.out_ready = 0; bus8.aluOP = 0; bus8.operand1 = 0; bus8.operand2 = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus32.result, bus32.result_hi, bus32.zeroFlag, bus32.ovfFlag, bus32.out_valid, bus32.busy} !== '0) begin
      n_err++; $display("[TB] FAIL reset outputs: got res=%h hi=%h z=%b o=%b ov=%b busy=%b want all 0",
                        bus32.result, bus32.result_hi, bus32.zeroFlag, bus32.ovfFlag, bus32.out_valid, bus32.busy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus32.in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset in_ready: got %b want 1", bus32.in_ready); end
  endtask

  task automatic test_single_cycle();
    run_check("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    run_check("sub_zero", ALU_SUB, 32'd5, 32'd5);
    run_check("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    run_check("slt_pos", ALU_SLT, 32'd1, 32'hFFFF_FFFF);
    run_check("nor_zero", ALU_NOR, 32'd0, 32'd0);
    run_check("sub_ovf", ALU_SUB, 32'h8000_0000, 32'd1);
    run_check("bad_op", 4'b0101, 32'h1234, 32'h5678);
  endtask

  task automatic test_muldiv();
    int lat, bc;
    issue32(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    n_cmp += 4;
    if (lat !== 33) begin n_err++; $display("[TB] FAIL mul_max latency: got %0d want 33", lat); end
    if (bc !== 32) begin n_err++; $display("[TB] FAIL mul_max busy cycles: got %0d want 32", bc); end
    if (bus32.result_hi !== 32'hFFFF_FFFE) begin n_err++; $display("[TB] FAIL mul_max hi: got %h want fffffffe", bus32.result_hi); end
    if (bus32.result !== 32'h1) begin n_err++; $display("[TB] FAIL mul_max lo: got %h want 00000001", bus32.result); end
    drain32();
    run_check("div_100_7", ALU_DIV, 32'd100, 32'd7);
    run_check("div_by_zero", ALU_DIV, 32'd9, 32'd0);
  endtask

  task automatic test_random();
    logic [3:0] ops [11];
    logic [3:0] op;
    logic [31:0] a, b;
    ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB, ALU_SLT, ALU_NOR, ALU_MUL, ALU_DIV, 4'b0100, 4'b1111};
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 10)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = a;
        2: b = 32'($urandom_range(1, 300));
        default: ;
      endcase
      run_check("random", op, a, b);
    end
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    @(negedge clk);
    bus32.aluOP = ALU_ADD; bus32.operand1 = 32'd1; bus32.operand2 = 32'd2;
    bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus32.out_valid) begin
        nvalid++;
        n_cmp++;
        if (bus32.result !== 32'd3) begin n_err++; $display("[TB] FAIL b2b result: got %h want 3", bus32.result); end
      end
    end
    bus32.in_valid = 1'b0;
    @(posedge clk);
    #1;
    bus32.out_ready = 1'b0;
    n_cmp++;
    if (nvalid !== 4) begin n_err++; $display("[TB] FAIL b2b throughput: got %0d valid cycles want 4", nvalid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, elo, ehi;
    logic ez, eo;
    int elat, lat, bc;
    a = $urandom; b = $urandom;
    model(ALU_MUL, a, b, elo, ehi, ez, eo, elat);
    issue32(ALU_MUL, a, b, lat, bc);
    n_cmp++;
    if (lat !== 33) begin n_err++; $display("[TB] FAIL bp latency: got %0d want 33", lat); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) begin
        bus32.aluOP = ALU_ADD; bus32.operand1 = 32'd1; bus32.operand2 = 32'd1; bus32.in_valid = 1'b1;
      end
      if (i == 8) bus32.in_valid = 1'b0;
      n_cmp += 4;
      if (bus32.out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp out_valid cyc %0d: got %b want 1", i, bus32.out_valid); end
      if (bus32.in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bp in_ready cyc %0d: got %b want 0", i, bus32.in_ready); end
      if (bus32.result !== elo) begin n_err++; $display("[TB] FAIL bp result cyc %0d: got %h want %h", i, bus32.result, elo); end
      if (bus32.result_hi !== ehi) begin n_err++; $display("[TB] FAIL bp result_hi cyc %0d: got %h want %h", i, bus32.result_hi, ehi); end
    end
    drain32();
    n_cmp += 2;
    if (bus32.out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bp release out_valid: got %b want 0", bus32.out_valid); end
    if (bus32.in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bp release in_ready: got %b want 1", bus32.in_ready); end
  endtask

  task automatic test_reset_mid_div();
    int lat, bc;
    issue32(ALU_XOR, 32'hF0, 32'h0F, lat, bc);
    drain32();
    @(negedge clk);
    bus32.aluOP = ALU_DIV; bus32.operand1 = $urandom; bus32.operand2 = 32'd7; bus32.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus32.in_valid = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus32.busy !== 1'b1) begin n_err++; $display("[TB] FAIL abort pre busy: got %b want 1", bus32.busy); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus32.result, bus32.result_hi, bus32.zeroFlag, bus32.ovfFlag, bus32.out_valid, bus32.busy, bus32.in_ready} !== '0) begin
      n_err++; $display("[TB] FAIL abort outputs: got res=%h hi=%h z=%b o=%b ov=%b busy=%b rdy=%b want all 0",
                        bus32.result, bus32.result_hi, bus32.zeroFlag, bus32.ovfFlag, bus32.out_valid, bus32.busy, bus32.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus32.in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL abort release in_ready: got %b want 1", bus32.in_ready); end
    run_check("post_abort_add", ALU_ADD, 32'd2, 32'd3);
  endtask

  task automatic test_width8();
    int lat, bc;
    issue8(ALU_ADD, 8'h7F, 8'h01, lat, bc);
    n_cmp += 5;
    if (lat !== 1) begin n_err++; $display("[TB] FAIL w8 add latency: got %0d want 1", lat); end
    if (bus8.result !== 8'h80) begin n_err++; $display("[TB] FAIL w8 add result: got %h want 80", bus8.result); end
    if (bus8.ovfFlag !== 1'b1) begin n_err++; $display("[TB] FAIL w8 add ovf: got %b want 1", bus8.ovfFlag); end
    if (bus8.zeroFlag !== 1'b0) begin n_err++; $display("[TB] FAIL w8 add zero: got %b want 0", bus8.zeroFlag); end
    if (bus8.result_hi !== 8'h00) begin n_err++; $display("[TB] FAIL w8 add hi: got %h want 00", bus8.result_hi); end
    @(negedge clk); bus8.out_ready = 1'b1; @(posedge clk); #1; bus8.out_ready = 1'b0;
    issue8(ALU_MUL, 8'hFF, 8'hFF, lat, bc);
    n_cmp += 4;
    if (lat !== 9) begin n_err++; $display("[TB] FAIL w8 mul latency: got %0d want 9", lat); end
    if (bc !== 8) begin n_err++; $display("[TB] FAIL w8 mul busy cycles: got %0d want 8", bc); end
    if (bus8.result_hi !== 8'hFE) begin n_err++; $display("[TB] FAIL w8 mul hi: got %h want fe", bus8.result_hi); end
    if (bus8.result !== 8'h01) begin n_err++; $display("[TB] FAIL w8 mul lo: got %h want 01", bus8.result); end
    @(negedge clk); bus8.out_ready = 1'b1; @(posedge clk); #1; bus8.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_cycle();
    test_muldiv();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_div();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
